sha256_round_ctrl: RTL

//  Sequences the combinational SHA-256 round datapath over one 512-bit block.

---
 rtl/sha256_round_ctrl_if.sv | 41 ++++
 rtl/sha256_round_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl_if.sv
// sha256_round_ctrl_if
//   Groups the handshake and datapath signals of the SHA-256 round controller.
//   master : upstream W+K source and round datapath (drives start, wk, next state)
//   slave  : the round controller
//   Signals:
//     start, first_blk     block start request and IV-load select
//     wk_i, wk_valid       W[t]+K[t] word and its valid
//     wk_ready             controller accepts wk_i this cycle
//     rnd_state_o          {a..h} to the round datapath, a in [255:224]
//     wk_o                 wk word forwarded to the round datapath
//     rnd_next_i           next-round {a..h} from the round datapath
//     round_o              index of the round being executed
//     busy                 high while rounds or the final fold are in progress
//     digest_o             {H0..H7}, H0 in [255:224]
//     digest_valid         one-cycle pulse when digest_o is final
interface sha256_round_ctrl_if #(
   parameter int unsigned CNT_W = 6
);
   logic             start;
   logic             first_blk;
   logic [31:0]      wk_i;
   logic             wk_valid;
   logic             wk_ready;
   logic [255:0]     rnd_state_o;
   logic [31:0]      wk_o;
   logic [255:0]     rnd_next_i;
   logic [CNT_W-1:0] round_o;
   logic             busy;
   logic [255:0]     digest_o;
   logic             digest_valid;

   modport master (
      output start, first_blk, wk_i, wk_valid, rnd_next_i,
      input  wk_ready, rnd_state_o, wk_o, round_o, busy, digest_o, digest_valid
   );

   modport slave (
      input  start, first_blk, wk_i, wk_valid, rnd_next_i,
      output wk_ready, rnd_state_o, wk_o, round_o, busy, digest_o, digest_valid
   );
endinterface

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Sequences an external combinational SHA-256 round datapath over one
//   512-bit block. Holds the working registers a..h and the chaining hash
//   H0..H7, advances a..h once per accepted W+K word, folds the working state
//   into H after the last round and pulses digest_valid.
//   Ports:
//     clk   clock, all state on the rising edge
//     rst   asynchronous, active-high reset
//     bus   sha256_round_ctrl_if slave modport (handshake, datapath, digest)
module sha256_round_ctrl #(
   parameter int unsigned ROUNDS = 64,
   parameter int unsigned CNT_W  = $clog2(ROUNDS)
) (
   input logic              clk,
   input logic              rst,
   sha256_round_ctrl_if.slave bus
);

   localparam logic [7:0][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StFinal,
      StDone
   } state_e;

   state_e           state_q;
   // Element 7 is a / H0 so the packed vector matches the bus word order.
   logic [7:0][31:0] work_q;
   logic [7:0][31:0] h_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wk_ready_q;
   logic             busy_q;
   logic             digest_valid_q;

   logic             last_round;

   assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         work_q         <= '0;
         h_q            <= '0;
         cnt_q          <= '0;
         wk_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (bus.first_blk) begin
                     h_q    <= IV;
                     work_q <= IV;
                  end else begin
                     work_q <= h_q;
                  end
                  cnt_q      <= '0;
                  wk_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= StRound;
               end
            end
            StRound: begin
               // wk_ready is high for the whole of this state, so a beat is wk_valid alone.
               if (bus.wk_valid) begin
                  work_q <= bus.rnd_next_i;
                  if (last_round) begin
                     cnt_q      <= '0;
                     wk_ready_q <= 1'b0;
                     state_q    <= StFinal;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            StFinal: begin
               for (int i = 0; i < 8; i++) begin
                  h_q[i[2:0]] <= h_q[i[2:0]] + work_q[i[2:0]];
               end
               busy_q         <= 1'b0;
               digest_valid_q <= 1'b1;
               state_q        <= StDone;
            end
            StDone: begin
               digest_valid_q <= 1'b0;
               state_q        <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.wk_ready     = wk_ready_q;
   assign bus.busy         = busy_q;
   assign bus.digest_valid = digest_valid_q;
   assign bus.rnd_state_o  = work_q;
   assign bus.digest_o     = h_q;
   assign bus.round_o      = cnt_q;
   assign bus.wk_o         = bus.wk_i;

endmodule
